fir_tap_window_8x8: RTL and testbench
=====================================

# fir_tap_window_8x8

Streaming tap-delay-line front end for the 8-bit, 8-tap parallel FIR datapath. It accepts one 8-bit sample per handshake and maintains an 8-deep sample history. Once the history is full, it presents the 64-bit window as a registered, handshaked output that drives the FIR's `data_in` bus directly. It supports output backpressure, synchronous flush and optional integer decimation.

## Interface
- `DECIM`, default 1: emit one window every `DECIM` accepted samples once full; legal range 1..16.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush, active-high.
- `sample_in`  in  8  unsigned input sample.
- `sample_valid`  in  1  `sample_in` is valid this cycle.
- `sample_ready`  out  1  block can accept a sample this cycle.
- `window_data`  out  64  lane k = bits [8k+7:8k]; lane 0 = newest sample x[n], lane 7 = oldest x[n-7].
- `window_valid`  out  1  `window_data` holds a valid window.
- `window_ready`  in  1  consumer takes the window this cycle.
- `fill_level`  out  4  samples in history, saturating at 8.

## Operation
- **Accept.** A sample is accepted when `sample_valid & sample_ready`.
- **Ready rule.**
  - `sample_ready = !clear & (!window_valid | window_ready)`.
  - It is a combinational function of registered state and the inputs `clear` and `window_ready`.
- **Shift on accept.**
  - The history shifts one lane toward lane 7; the previous lane 7 is discarded.
  - `sample_in` enters lane 0.
- **fill_level.** Increments on each accept, saturating at 8.
- **States:**
  - FILLING: `fill_level` < 8, covering 0..7.
  - RUNNING: `fill_level` == 8.
  - FILLING→RUNNING on the 8th accept. Only `rst` or `clear` returns the block to FILLING.
- **Decimation phase counter** `phase`, range 0..DECIM-1:
  - Held at 0 in FILLING.
  - On each accept whose post-shift fill is 8, a window is emitted if `phase`==0.
  - On that same accept, `phase` advances as (`phase`+1) mod DECIM.
  - With DECIM=1, every accept in RUNNING emits a window.
- **Emit.** `window_data` is loaded with the post-shift history, and `window_valid` is set to 1.
- **Output register:**
  - `window_data` and `window_valid` are registered.
  - They hold stable while `window_valid & !window_ready`.
  - `window_valid` clears on `window_ready` unless a new emit occurs in the same cycle. A new emit in the same cycle is a back-to-back handoff: the register is reloaded and `window_valid` stays 1.
- **Arithmetic.** None; the block is pure data movement. Samples are unsigned and pass through bit-exact.
- **clear** (sync), in the cycle it is high:
  - The sample is dropped, because `sample_ready` is 0.
  - At the next edge: history is zeroed, `fill_level`=0, `phase`=0, `window_valid`=0, `window_data`=0.
  - `clear` has priority over any accept or emit in the same cycle.
- **Reset** (async, any time, including mid-window or with `window_valid` pending): outputs and state go immediately to the reset values.
  - `window_data`=0, `window_valid`=0, `fill_level`=0.
  - History=0, `phase`=0.
  - `sample_ready` then evaluates to 1 while `clear`=0.

## Timing
- **Latency.** An accept at edge k that emits gives `window_valid`=1 and the new `window_data` in the cycle after edge k, a 1-cycle latency.
- **Throughput.** 1 sample/cycle with `window_ready` held high. Handoff is back-to-back, with no bubble.
- **Backpressure.** While a window is pending and `window_ready`=0, `sample_ready`=0. No sample is lost and the history does not advance.
- **fill_level timing.** `fill_level` updates on the same edge as the shift.
- **First window.** The earliest first window after reset is the cycle after the 8th accept.
- **Decimation pattern.** With DECIM=D, windows are emitted on accepts 8, 8+D, 8+2D, …, counted since the last reset or clear.

## Test plan
- **Fill, DECIM=1.** Accept samples 0x01..0x08 on consecutive cycles with `window_ready`=1 → `window_valid` low for samples 1–7, `fill_level` 1..7. The cycle after the 8th accept, `window_data`=0x0102030405060708 and `fill_level`=8. Sample 0x09 → next window 0x0203040506070809.
- **Backpressure.** After the first window, hold `window_ready`=0 for 5 cycles with `sample_valid`=1 → `sample_ready`=0 for those 5 cycles and `window_data` stable. Raise `window_ready` → the next sample is accepted and the next window follows with no loss or duplication.
- **Decimation, DECIM=3.** Feed 0x01..0x0E → windows emitted only after samples 8, 11 and 14: 0x0102…08, 0x0405…0B, 0x0708…0E.
- **Clear during fill.** Accept 5 samples, then `clear`=1 together with `sample_valid`=1 → `sample_ready`=0 that cycle, then `fill_level`=0. Eight new samples 0xA0..0xA7 → window 0xA0A1A2A3A4A5A6A7, with no stale lanes.
- **Async reset mid-operation.** Assert `rst` asynchronously while `window_valid`=1 and `window_ready`=0 → `window_valid`, `window_data` and `fill_level` go to 0 before the next edge. After release, a refill is required before the next window.
- **Random stream vs. reference model.** Random `sample_valid`/`window_ready` stream, DECIM=1 and DECIM=2 → every window matches a software 8-deep shift-register model. The bench compares each window against the FIR sum Σ(k+1)·lane k.

Source files
------------

// File: rtl/fir_tap_window_8x8.sv
// fir_tap_window_8x8
// Streaming tap-delay-line front end for an 8-tap, 8-bit parallel FIR.
// Keeps an 8-deep history of accepted samples and, once the history is full,
// publishes the whole window as one registered, handshaked 64-bit word.
// Every DECIM-th accept emits a window.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   clear             synchronous flush (wins over accept/emit)
//   sample_in/valid   input sample stream
//   sample_ready      combinational: !clear & (!window_valid | window_ready)
//   window_data       lane k = [8k+7:8k], lane 0 newest, lane 7 oldest
//   window_valid      window_data holds an unconsumed window
//   window_ready      consumer takes the window this cycle
//   fill_level        samples in history, saturating at 8
module fir_tap_window_8x8 #(
   parameter int unsigned DECIM = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic [7:0]  sample_in,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic [63:0] window_data,
   output logic        window_valid,
   input  logic        window_ready,
   output logic [3:0]  fill_level
);

   typedef enum logic {FILLING, RUNNING} state_e;

   localparam int unsigned   PW      = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);

   state_e              state_q, state_d;
   logic [7:0][7:0]     hist_q, hist_d;
   logic [63:0]         win_q, win_d;
   logic                win_vld_q, win_vld_d;
   logic [3:0]          fill_q, fill_d;
   logic [PW-1:0]       phase_q, phase_d;
   logic                accept;
   logic                emit;

   // The output register can take a new window when it is empty or being
   // drained this cycle, which is what gives back-to-back handoff.
   assign sample_ready = !clear && (!win_vld_q || window_ready);
   assign accept       = sample_valid && sample_ready;

   always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      phase_d   = phase_q;
      win_d     = win_q;
      win_vld_d = win_vld_q && !window_ready;
      emit      = 1'b0;
      if (clear) begin
         state_d   = FILLING;
         hist_d    = '0;
         fill_d    = '0;
         phase_d   = '0;
         win_d     = '0;
         win_vld_d = 1'b0;
      end else if (accept) begin
         // Shift toward lane 7; new sample lands in lane 0.
         hist_d = {hist_q[6:0], sample_in};
         fill_d = (state_q == RUNNING) ? 4'd8 : fill_q + 4'd1;
         if (fill_d == 4'd8) begin
            state_d = RUNNING;
            emit    = (phase_q == '0);
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
         end
         if (emit) begin
            win_d     = hist_d;
            win_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FILLING;
         hist_q    <= '0;
         fill_q    <= '0;
         phase_q   <= '0;
         win_q     <= '0;
         win_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         phase_q   <= phase_d;
         win_q     <= win_d;
         win_vld_q <= win_vld_d;
      end
   end

   assign window_data  = win_q;
   assign window_valid = win_vld_q;
   assign fill_level   = fill_q;

endmodule

// File: tb/tb_fir_tap_window_8x8.sv
module tb_fir_tap_window_8x8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Three instances: index 0 DECIM=1, 1 DECIM=2, 2 DECIM=3.
   logic [2:0]        clr, sv, wr, sr, wv;
   logic [2:0][7:0]   sin;
   logic [2:0][63:0]  wd;
   logic [2:0][3:0]   fl;

   fir_tap_window_8x8 #(.DECIM(1)) u_d1 (
      .clk(clk), .rst(rst), .clear(clr[0]), .sample_in(sin[0]), .sample_valid(sv[0]),
      .sample_ready(sr[0]), .window_data(wd[0]), .window_valid(wv[0]),
      .window_ready(wr[0]), .fill_level(fl[0]));
   fir_tap_window_8x8 #(.DECIM(2)) u_d2 (
      .clk(clk), .rst(rst), .clear(clr[1]), .sample_in(sin[1]), .sample_valid(sv[1]),
      .sample_ready(sr[1]), .window_data(wd[1]), .window_valid(wv[1]),
      .window_ready(wr[1]), .fill_level(fl[1]));
   fir_tap_window_8x8 #(.DECIM(3)) u_d3 (
      .clk(clk), .rst(rst), .clear(clr[2]), .sample_in(sin[2]), .sample_valid(sv[2]),
      .sample_ready(sr[2]), .window_data(wd[2]), .window_valid(wv[2]),
      .window_ready(wr[2]), .fill_level(fl[2]));

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [7:0]  s;
      logic        vld;
      logic [63:0] data;
      logic [3:0]  fill;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Window whose lane k holds sample value n-k.
   function automatic logic [63:0] win_seq(input int n);
      logic [63:0] w;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(n - k);
      return w;
   endfunction

   function automatic int fir_sum(input logic [63:0] w);
      int s = 0;
      for (int k = 0; k < 8; k++) s += (k + 1) * int'(w[8*k +: 8]);
      return s;
   endfunction

   task automatic rand_run(input int idx, input int d, input int ncyc);
      logic [7:0]  mh [8];
      int          mfill, mph;
      logic        mv, em, a_sv, a_wr, exp_sr;
      logic [7:0]  a_s;
      logic [63:0] md;
      clr[idx] = 1'b1; sv[idx] = 1'b0; wr[idx] = 1'b0;
      cyc();
      clr[idx] = 1'b0;
      for (int k = 0; k < 8; k++) mh[k] = 8'h00;
      mfill = 0; mph = 0; mv = 1'b0; md = '0;
      for (int c = 0; c < ncyc; c++) begin
         a_sv = ($urandom_range(0, 3) != 0);
         a_wr = ($urandom_range(0, 2) != 0);
         a_s  = 8'($urandom);
         sv[idx] = a_sv; wr[idx] = a_wr; sin[idx] = a_s;
         #1;
         exp_sr = !mv || a_wr;
         chk("rand_sample_ready", 64'(sr[idx]), 64'(exp_sr));
         cyc();
         em = 1'b0;
         if (a_sv && exp_sr) begin
            for (int k = 7; k > 0; k--) mh[k] = mh[k-1];
            mh[0] = a_s;
            if (mfill < 8) mfill++;
            if (mfill == 8) begin
               em  = (mph == 0);
               mph = (mph + 1) % d;
            end
         end
         if (em) begin
            for (int k = 0; k < 8; k++) md[8*k +: 8] = mh[k];
            mv = 1'b1;
         end else if (a_wr) begin
            mv = 1'b0;
         end
         chk("rand_window_valid", 64'(wv[idx]), 64'(mv));
         chk("rand_fill_level", 64'(fl[idx]), 64'(mfill));
         if (mv) begin
            chk("rand_window_data", wd[idx], md);
            chk("rand_fir_sum", 64'(fir_sum(wd[idx])), 64'(fir_sum(md)));
         end
      end
      sv[idx] = 1'b0; wr[idx] = 1'b1;
      cyc();
   endtask

   initial begin
      rst = 1'b1; clr = '0; sv = '0; wr = '0; sin = '0;
      tbl[0] = '{8'h01, 1'b0, 64'h0, 4'd1};
      tbl[1] = '{8'h02, 1'b0, 64'h0, 4'd2};
      tbl[2] = '{8'h03, 1'b0, 64'h0, 4'd3};
      tbl[3] = '{8'h04, 1'b0, 64'h0, 4'd4};
      tbl[4] = '{8'h05, 1'b0, 64'h0, 4'd5};
      tbl[5] = '{8'h06, 1'b0, 64'h0, 4'd6};
      tbl[6] = '{8'h07, 1'b0, 64'h0, 4'd7};
      tbl[7] = '{8'h08, 1'b1, 64'h0102030405060708, 4'd8};
      tbl[8] = '{8'h09, 1'b1, 64'h0203040506070809, 4'd8};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_window_data", wd[0], 64'h0);
      chk("reset_window_valid", 64'(wv[0]), 64'h0);
      chk("reset_fill_level", 64'(fl[0]), 64'h0);
      chk("reset_sample_ready", 64'(sr[0]), 64'h1);
      rst = 1'b0;
      cyc();

      // Fill with DECIM=1, table-driven.
      for (int i = 0; i < 9; i++) begin
         sv[0] = 1'b1; wr[0] = 1'b1; sin[0] = tbl[i].s;
         #1;
         chk("fill_sample_ready", 64'(sr[0]), 64'h1);
         cyc();
         chk("fill_window_valid", 64'(wv[0]), 64'(tbl[i].vld));
         chk("fill_window_data", wd[0], tbl[i].data);
         chk("fill_fill_level", 64'(fl[0]), 64'(tbl[i].fill));
      end

      // Backpressure: window 0x..09 pending, consumer stalls 5 cycles.
      wr[0] = 1'b0; sv[0] = 1'b1; sin[0] = 8'h0A;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_sample_ready", 64'(sr[0]), 64'h0);
         cyc();
         chk("bp_window_data_stable", wd[0], 64'h0203040506070809);
         chk("bp_window_valid", 64'(wv[0]), 64'h1);
      end
      wr[0] = 1'b1;
      #1;
      chk("bp_release_ready", 64'(sr[0]), 64'h1);
      cyc();
      chk("bp_next_window", wd[0], 64'h030405060708090A);
      chk("bp_next_valid", 64'(wv[0]), 64'h1);
      sv[0] = 1'b0;
      cyc();
      chk("bp_no_duplicate", 64'(wv[0]), 64'h0);

      // Decimation, DECIM=3.
      wr[2] = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         sv[2] = 1'b1; sin[2] = 8'(i);
         cyc();
         chk("dec3_window_valid", 64'(wv[2]), 64'(i == 8 || i == 11 || i == 14));
         if (i == 8 || i == 11 || i == 14) chk("dec3_window_data", wd[2], win_seq(i));
      end
      sv[2] = 1'b0;
      cyc();

      // Clear during fill.
      clr[0] = 1'b1;
      cyc();
      clr[0] = 1'b0;
      chk("clr_init_fill", 64'(fl[0]), 64'h0);
      for (int i = 0; i < 5; i++) begin
         sv[0] = 1'b1; sin[0] = 8'(8'h11 + i);
         cyc();
      end
      chk("clr_pre_fill", 64'(fl[0]), 64'd5);
      clr[0] = 1'b1; sv[0] = 1'b1; sin[0] = 8'h16;
      #1;
      chk("clr_sample_ready", 64'(sr[0]), 64'h0);
      cyc();
      clr[0] = 1'b0;
      chk("clr_fill_level", 64'(fl[0]), 64'h0);
      chk("clr_window_data", wd[0], 64'h0);
      for (int i = 0; i < 8; i++) begin
         sv[0] = 1'b1; sin[0] = 8'(8'hA0 + i);
         cyc();
         if (i == 6) chk("clr_refill_no_window", 64'(wv[0]), 64'h0);
      end
      chk("clr_window", wd[0], 64'hA0A1A2A3A4A5A6A7);
      chk("clr_window_valid", 64'(wv[0]), 64'h1);
      chk("clr_fill_full", 64'(fl[0]), 64'd8);

      // Async reset with a window pending and stalled.
      sv[0] = 1'b0; wr[0] = 1'b0;
      cyc();
      chk("ar_pending", 64'(wv[0]), 64'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_window_valid", 64'(wv[0]), 64'h0);
      chk("ar_window_data", wd[0], 64'h0);
      chk("ar_fill_level", 64'(fl[0]), 64'h0);
      chk("ar_sample_ready", 64'(sr[0]), 64'h1);
      #2;
      rst = 1'b0;
      cyc();
      wr[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sv[0] = 1'b1; sin[0] = 8'(8'h31 + i);
         cyc();
         if (i == 6) chk("ar_refill_no_window", 64'(wv[0]), 64'h0);
      end
      chk("ar_refill_window", wd[0], 64'h3132333435363738);
      sv[0] = 1'b0;
      cyc();

      // Random streams against the shift-register model.
      rand_run(0, 1, 300);
      rand_run(1, 2, 300);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
